// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86-64 icodes, status codes, register IDs and control FSM encoding
package y86_pkg;
  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;
  localparam logic [2:0] SBUB = 3'd0;
  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SHLT = 3'd2;
  localparam logic [2:0] SADR = 3'd3;
  localparam logic [2:0] SINS = 3'd4;
  localparam logic [3:0] RNONE = 4'hF;
  typedef enum logic [1:0] {S_RUN = 2'd0, S_DRAIN = 2'd1, S_PAUSED = 2'd2, S_HALTED = 2'd3} state_t;
  function automatic logic is_exc(input logic [2:0] s);
    return s == SHLT || s == SADR || s == SINS;
  endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones, synchronous clear has priority
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);
  logic [CNT_W-1:0] r_cnt;
  // clear, otherwise count until every bit is set
  always_ff @(posedge clk)
    if (i_clr) r_cnt <= '0;
    else if (i_inc && !(&r_cnt)) r_cnt <= r_cnt + 1'b1;
  assign o_cnt = r_cnt;
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: Y86-64 pipeline stall/bubble control, processor status FSM and perf counters
module pipe_ctrl
  import y86_pkg::*;
#(
  parameter int REG_W     = 4,
  parameter int CNT_W     = 32,
  parameter int DRAIN_CYC = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       d_icode,
  input  logic [REG_W-1:0] d_srcA,
  input  logic [REG_W-1:0] d_srcB,
  input  logic [3:0]       e_icode,
  input  logic [REG_W-1:0] e_dstM,
  input  logic             e_cnd,
  input  logic [3:0]       m_icode,
  input  logic [2:0]       m_stat,
  input  logic [3:0]       w_icode,
  input  logic [2:0]       w_stat,
  input  logic             dbg_halt,
  input  logic             dbg_resume,
  output logic             f_stall,
  output logic             d_stall,
  output logic             d_bubble,
  output logic             e_bubble,
  output logic             m_bubble,
  output logic             w_stall,
  output logic             set_cc_en,
  output logic [2:0]       proc_stat,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] ret_cnt,
  output logic [CNT_W-1:0] stall_cnt
);
  localparam int DW = $clog2(DRAIN_CYC + 1);
  state_t        r_state;
  logic [2:0]    r_stat;
  logic [DW-1:0] r_drain;
  logic          w_lu, w_mp, w_rt, w_hold, w_drain, w_mexc, w_wexc;
  // hazard detection and state decode, purely from current inputs
  always_comb begin
    w_lu    = (e_icode == IMRMOVQ || e_icode == IPOPQ) && e_dstM != '1 &&
              (e_dstM == d_srcA || e_dstM == d_srcB);
    w_mp    = e_icode == IJXX && !e_cnd;
    w_rt    = d_icode == IRET || e_icode == IRET || m_icode == IRET;
    w_hold  = r_state == S_PAUSED || r_state == S_HALTED;
    w_drain = r_state == S_DRAIN;
    w_mexc  = is_exc(m_stat);
    w_wexc  = is_exc(w_stat);
  end
  // same-cycle controls: reset flushes, hold freezes, drain keeps fetch frozen and D empty
  always_comb begin
    f_stall   = !reset && (w_hold || w_drain || w_lu || w_rt);
    d_stall   = !reset && (w_hold || w_lu);
    d_bubble  = reset || (!w_hold && (w_drain || w_mp || (w_rt && !w_lu)));
    e_bubble  = reset || (!w_hold && (w_mp || w_lu));
    m_bubble  = reset || (!w_hold && (w_mexc || w_wexc));
    w_stall   = !reset && (w_hold || w_wexc);
    set_cc_en = !reset && !w_hold && e_icode == IOPQ && !w_mexc && !w_wexc;
  end
  // status FSM: an exception reaching W halts for good and beats a debug pause
  always_ff @(posedge clk)
    if (reset) begin
      r_state <= S_RUN;
      r_stat  <= SAOK;
      r_drain <= '0;
    end else begin
      case (r_state)
        S_RUN:
          if (w_wexc) begin
            r_state <= S_HALTED;
            r_stat  <= w_stat;
          end else if (dbg_halt) begin
            r_state <= S_DRAIN;
            r_drain <= DW'(DRAIN_CYC);
          end
        S_DRAIN:
          if (w_wexc) begin
            r_state <= S_HALTED;
            r_stat  <= w_stat;
          end else if (r_drain <= DW'(1)) r_state <= S_PAUSED;
          else r_drain <= r_drain - 1'b1;
        S_PAUSED:
          if (dbg_resume) r_state <= S_RUN;
        default: ;
      endcase
    end
  assign state     = r_state;
  assign proc_stat = r_stat;
  sat_counter #(.CNT_W(CNT_W)) u_cyc (
    .clk(clk), .i_clr(reset), .i_inc(r_state != S_HALTED), .o_cnt(cyc_cnt)
  );
  sat_counter #(.CNT_W(CNT_W)) u_ret (
    .clk(clk), .i_clr(reset),
    .i_inc(w_stat == SAOK && w_icode != INOP && (r_state == S_RUN || w_drain)),
    .o_cnt(ret_cnt)
  );
  sat_counter #(.CNT_W(CNT_W)) u_stall (
    .clk(clk), .i_clr(reset), .i_inc(r_state == S_RUN && f_stall), .o_cnt(stall_cnt)
  );
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed vectors with a queue scoreboard checked at the falling edge
module tb_pipe_ctrl;
  localparam int CW = 8;
  logic clk = 1'b0;
  logic reset, e_cnd, dbg_halt, dbg_resume;
  logic [3:0] d_icode, e_icode, m_icode, w_icode, d_srcA, d_srcB, e_dstM;
  logic [2:0] m_stat, w_stat, proc_stat;
  logic f_stall, d_stall, d_bubble, e_bubble, m_bubble, w_stall, set_cc_en;
  logic [1:0] state;
  logic [CW-1:0] cyc_cnt, ret_cnt, stall_cnt;
  logic [6:0] ctl;
  typedef struct {
    string         name;
    logic [6:0]    ctl;
    logic [1:0]    st;
    logic [2:0]    ps;
    logic [CW-1:0] cyc, ret, stl;
  } exp_t;
  exp_t q[$];
  int vectors = 0;
  int errors  = 0;

  pipe_ctrl #(.REG_W(4), .CNT_W(CW), .DRAIN_CYC(4)) dut (
    .clk(clk), .reset(reset), .d_icode(d_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .e_icode(e_icode), .e_dstM(e_dstM), .e_cnd(e_cnd), .m_icode(m_icode), .m_stat(m_stat),
    .w_icode(w_icode), .w_stat(w_stat), .dbg_halt(dbg_halt), .dbg_resume(dbg_resume),
    .f_stall(f_stall), .d_stall(d_stall), .d_bubble(d_bubble), .e_bubble(e_bubble),
    .m_bubble(m_bubble), .w_stall(w_stall), .set_cc_en(set_cc_en), .proc_stat(proc_stat),
    .state(state), .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;
  assign ctl = {f_stall, d_stall, d_bubble, e_bubble, m_bubble, w_stall, set_cc_en};

  always @(negedge clk)
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      vectors++;
      if (ctl !== e.ctl || state !== e.st || proc_stat !== e.ps ||
          cyc_cnt !== e.cyc || ret_cnt !== e.ret || stall_cnt !== e.stl) begin
        errors++;
        $display("FAIL %s: got ctl=%b st=%0d ps=%0d cyc=%0d ret=%0d stall=%0d, want ctl=%b st=%0d ps=%0d cyc=%0d ret=%0d stall=%0d",
                 e.name, ctl, state, proc_stat, cyc_cnt, ret_cnt, stall_cnt,
                 e.ctl, e.st, e.ps, e.cyc, e.ret, e.stl);
      end
    end

  task automatic step(input string n, input logic [6:0] c, input logic [1:0] s,
                      input logic [2:0] p, input int cy, input int rt, input int sl);
    q.push_back('{n, c, s, p, CW'(cy), CW'(rt), CW'(sl)});
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    d_icode = 4'h1; e_icode = 4'h1; m_icode = 4'h1; w_icode = 4'h1;
    d_srcA = 4'hF; d_srcB = 4'hF; e_dstM = 4'hF; e_cnd = 1'b0;
    m_stat = 3'd1; w_stat = 3'd1; dbg_halt = 1'b0; dbg_resume = 1'b0;
  endtask

  // ctl bit order: f_stall d_stall d_bubble e_bubble m_bubble w_stall set_cc_en
  initial begin
    reset = 1'b1;
    idle();
    @(posedge clk);
    #1;
    step("reset", 7'b0011100, 0, 1, 0, 0, 0);
    reset = 1'b0;
    step("idle", 7'b0000000, 0, 1, 0, 0, 0);
    e_icode = 4'h5; e_dstM = 4'd3; d_srcA = 4'd3;
    step("lu_srcA", 7'b1101000, 0, 1, 1, 0, 0);
    idle();
    step("lu_done", 7'b0000000, 0, 1, 2, 0, 1);
    e_icode = 4'hB;
    step("lu_rnone", 7'b0000000, 0, 1, 3, 0, 1);
    e_dstM = 4'd2; d_srcB = 4'd2;
    step("lu_srcB", 7'b1101000, 0, 1, 4, 0, 1);
    idle(); e_icode = 4'h7;
    step("mispredict", 7'b0011000, 0, 1, 5, 0, 2);
    e_cnd = 1'b1;
    step("jxx_taken", 7'b0000000, 0, 1, 6, 0, 2);
    idle(); e_icode = 4'h6;
    step("opq_cc", 7'b0000001, 0, 1, 7, 0, 2);
    idle(); d_icode = 4'h9;
    step("ret_d", 7'b1010000, 0, 1, 8, 0, 2);
    idle(); e_icode = 4'h9;
    step("ret_e", 7'b1010000, 0, 1, 9, 0, 3);
    idle(); m_icode = 4'h9;
    step("ret_m", 7'b1010000, 0, 1, 10, 0, 4);
    idle(); d_icode = 4'h9; d_srcA = 4'd4; e_icode = 4'h5; e_dstM = 4'd4;
    step("ret_lu", 7'b1101000, 0, 1, 11, 0, 5);
    idle(); e_icode = 4'h9;
    step("ret_e2", 7'b1010000, 0, 1, 12, 0, 6);
    idle(); m_icode = 4'h9;
    step("ret_m2", 7'b1010000, 0, 1, 13, 0, 7);
    idle(); d_icode = 4'h9; e_icode = 4'h7;
    step("mp_ret", 7'b1011000, 0, 1, 14, 0, 8);
    idle(); w_icode = 4'h6;
    step("retire", 7'b0000000, 0, 1, 15, 0, 9);
    w_stat = 3'd0;
    step("retire_bub", 7'b0000000, 0, 1, 16, 1, 9);
    w_stat = 3'd1; dbg_halt = 1'b1;
    step("dbg_req", 7'b0000000, 0, 1, 17, 1, 9);
    step("drain1", 7'b1010000, 1, 1, 18, 2, 9);
    step("drain2", 7'b1010000, 1, 1, 19, 3, 9);
    step("drain3", 7'b1010000, 1, 1, 20, 4, 9);
    step("drain4", 7'b1010000, 1, 1, 21, 5, 9);
    e_icode = 4'h6;
    step("paused", 7'b1100010, 2, 1, 22, 6, 9);
    dbg_halt = 1'b0;
    step("paused_hold", 7'b1100010, 2, 1, 23, 6, 9);
    dbg_resume = 1'b1;
    step("resume", 7'b1100010, 2, 1, 24, 6, 9);
    dbg_resume = 1'b0; e_icode = 4'h1;
    step("resumed", 7'b0000000, 0, 1, 25, 6, 9);
    idle(); dbg_resume = 1'b1;
    step("resume_in_run", 7'b0000000, 0, 1, 26, 7, 9);
    dbg_resume = 1'b0;
    step("run_after", 7'b0000000, 0, 1, 27, 7, 9);
    m_stat = 3'd3; e_icode = 4'h6;
    step("adr_in_m", 7'b0000100, 0, 1, 28, 7, 9);
    m_stat = 3'd1; w_stat = 3'd3; dbg_halt = 1'b1;
    step("adr_in_w", 7'b0000110, 0, 1, 29, 7, 9);
    idle(); w_icode = 4'h6; dbg_resume = 1'b1;
    step("halted", 7'b1100010, 3, 3, 30, 7, 9);
    dbg_resume = 1'b0;
    step("halted_hold", 7'b1100010, 3, 3, 30, 7, 9);
    reset = 1'b1;
    step("halt_reset", 7'b0011100, 3, 3, 30, 7, 9);
    reset = 1'b0; idle();
    step("after_reset", 7'b0000000, 0, 1, 0, 0, 0);
    d_icode = 4'h9; w_icode = 4'h6;
    for (int i = 0; i < 260; i++) begin
      @(posedge clk);
      #1;
    end
    idle(); dbg_halt = 1'b1;
    step("saturated", 7'b0000000, 0, 1, 255, 255, 255);
    step("sat_drain", 7'b1010000, 1, 1, 255, 255, 255);
    reset = 1'b1;
    step("drain_reset", 7'b0011100, 1, 1, 255, 255, 255);
    reset = 1'b0; dbg_halt = 1'b0;
    step("post_reset", 7'b0000000, 0, 1, 0, 0, 0);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
